machine_seq_ctrl: RTL
=====================

Name: machine_seq_ctrl

Overview:
- Job sequencer that drives the 3-bit sequence-detector FSM (JK-flip-flop machine with serial input x, outputs F and S[2:0]).
- On start, it latches a parallel pattern word and clears the machine for one cycle.
- It then shifts the pattern into the machine's x input MSB-first, one bit per clock, and counts cycles where F is high.
- It captures the machine's final state and pulses done, so software and testbenches can run whole detection jobs through a handshake.

Parameters:
- WIDTH, 8, pattern word width in bits.
- LEN_W, 4, width of the len port; must hold WIDTH.
- CNT_W, 4, width of hit_count.

Ports:
- CLK  input  1  single clock, rising edge.
- RESET  input  1  asynchronous, active-low reset.
- start  input  1  job request; sampled only in IDLE.
- abort  input  1  cancels a running job.
- data_in  input  WIDTH  pattern word; latched on an accepted start.
- len  input  LEN_W  number of bits to shift; latched on an accepted start.
- F_in  input  1  machine F output.
- S_in  input  3  machine state S[2:0].
- x_out  output  1  serial bit to the machine x input.
- m_clr_n  output  1  active-low machine job-clear; integration ANDs it with RESET into the machine's reset.
- busy  output  1  job in progress.
- done  output  1  one-cycle completion pulse.
- hit_count  output  CNT_W  number of F_in-high cycles in the last job.
- last_state  output  3  S_in captured at end of job.

Behaviour:
- States: IDLE, CLEAR, SHIFT, DRAIN, DONE.
- Reset (RESET=0, asynchronous):
  - state=IDLE.
  - shift register, bit counter, hit_count and last_state = 0.
  - x_out=0, busy=0, done=0, m_clr_n=1.
- IDLE, start=1: latch data_in into the shift register and min(len, WIDTH) into the bit counter; clear hit_count; go to CLEAR. start=0 stays in IDLE.
- CLEAR: exactly one cycle.
  - m_clr_n=0 and busy=1.
  - Next state is SHIFT if the counter is nonzero, otherwise DRAIN.
- SHIFT:
  - x_out = shift register MSB (combinational from the register), busy=1.
  - Each clock: shift left (fill 0) and decrement the counter.
  - Leave for DRAIN on the edge where the counter goes 1 -> 0.
  - Each bit is therefore presented for exactly one cycle.
- DRAIN: one cycle, busy=1, x_out=0; last_state <= S_in on the exit edge. This cycle observes F caused by the final bit.
- DONE: one cycle, done=1, busy=0; then IDLE.
- Hit counting:
  - In SHIFT and DRAIN, hit_count increments on each clock where F_in=1.
  - It saturates at all-ones with no wrap.
  - F_in is ignored in IDLE, CLEAR and DONE.
- Latency:
  - start accepted on edge 0: CLEAR in cycle 1; SHIFT in cycles 2..L+1; DRAIN in cycle L+2; done=1 in cycle L+3.
  - len=0: CLEAR, DRAIN, DONE, with done=1 in cycle 3.
- start in any non-IDLE state (including DONE) is ignored with no queuing. data_in and len may change freely after acceptance.
- abort=1 in CLEAR, SHIFT or DRAIN:
  - Next state IDLE; no done pulse; last_state unchanged.
  - hit_count keeps its partial value; x_out=0 from the next cycle.
  - abort is ignored in IDLE and DONE. If start and abort are both high in IDLE, start wins.
- RESET asserted mid-job: immediate return to reset values; no done pulse.
- Outside SHIFT, x_out=0. Outside CLEAR, m_clr_n=1.
- hit_count and last_state hold their values until the next accepted start (hit_count cleared) or DRAIN exit (last_state).

Test Plan:
- Reset checks: hold RESET=0 while start=1 and F_in=1 -> all outputs at reset values. Release RESET -> IDLE, no activity until start.
- Basic job:
  - Stimulus: start with data_in=8'b1011_0010, len=8, F_in=0.
  - Required: m_clr_n=0 in cycle 1 only; x_out sequence 1,0,1,1,0,0,1,0 in cycles 2..9; busy=1 in cycles 1..10; done=1 in cycle 11 only; hit_count=0.
- Short job and counting:
  - Stimulus: len=3, data_in=8'b1100_0000; F_in forced 1 in SHIFT cycles 2 and 3 and in the DRAIN cycle; S_in=3'b111 in DRAIN.
  - Required: x_out 1,1,0; hit_count=3; last_state=3'b111; done in cycle 6.
- Edge lengths:
  - len=0 -> done in cycle 3, x_out never 1, hit_count=0.
  - len=12 -> clamped to 8 bits, done in cycle 11.
- Saturation and ignored start: F_in=1 throughout an 8-bit job with CNT_W=3 -> hit_count=7 with no wrap. start pulsed mid-SHIFT -> ignored, no second job.
- Abort and back-to-back:
  - abort in the 3rd SHIFT cycle -> IDLE next cycle, no done, x_out=0.
  - start held high through DONE -> new job is accepted only on the following IDLE cycle, and hit_count is cleared at that acceptance.

Source files
------------

// File: rtl/machine_seq_ctrl.sv
// machine_seq_ctrl
//   Job sequencer for the 3-bit JK sequence-detector machine. On an accepted
//   start it latches a pattern word, holds the machine in job-clear for one
//   cycle, streams the pattern MSB-first into the machine's x input, counts
//   cycles where F is high, captures the final machine state and pulses done.
//
// Ports
//   CLK         rising-edge clock
//   RESET       asynchronous active-low reset
//   start       job request, only honoured in IDLE
//   abort       cancels a job in CLEAR, SHIFT or DRAIN
//   data_in     pattern word, latched on an accepted start
//   len         number of bits to shift, clamped to WIDTH on acceptance
//   F_in        machine F output
//   S_in        machine state S[2:0]
//   x_out       serial bit to the machine x input
//   m_clr_n     active-low machine job-clear (low for the CLEAR cycle only)
//   busy        job in progress (CLEAR, SHIFT, DRAIN)
//   done        one-cycle completion pulse
//   hit_count   saturating count of F_in-high cycles in the last job
//   last_state  S_in captured on the DRAIN exit edge

module machine_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] data_in,
  input  logic [LEN_W-1:0] len,
  input  logic             F_in,
  input  logic [2:0]       S_in,
  output logic             x_out,
  output logic             m_clr_n,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] hit_count,
  output logic [2:0]       last_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hit_q, hit_d;
  logic [2:0]       last_q, last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             m_clr_n_q, m_clr_n_d;

  logic [LEN_W-1:0] len_clamped;
  logic [CNT_W-1:0] hit_inc;

  assign len_clamped = (len > WIDTH_L) ? WIDTH_L : len;

  // Saturating increment: stick at all-ones rather than wrapping.
  assign hit_inc = (hit_q == {CNT_W{1'b1}}) ? hit_q : hit_q + CNT_W'(1);

  // Next-state and datapath. busy/done/m_clr_n are decoded from the next
  // state so they come straight out of flops, aligned with state_q.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    hit_d   = hit_q;
    last_d  = last_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d = data_in;
          cnt_d   = len_clamped;
          hit_d   = '0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        if (abort)              state_d = IDLE;
        else if (cnt_q != '0)   state_d = SHIFT;
        else                    state_d = DRAIN;
      end
      SHIFT: begin
        if (F_in) hit_d = hit_inc;
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        cnt_d   = cnt_q - LEN_W'(1);
        if (abort)                   state_d = IDLE;
        else if (cnt_q == LEN_W'(1)) state_d = DRAIN;
      end
      DRAIN: begin
        // The final bit's effect on F is visible during this cycle.
        if (F_in) hit_d = hit_inc;
        if (abort) begin
          state_d = IDLE;
        end else begin
          last_d  = S_in;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d    = (state_d == CLEAR) || (state_d == SHIFT) || (state_d == DRAIN);
    done_d    = (state_d == DONE);
    m_clr_n_d = (state_d != CLEAR);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      hit_q     <= '0;
      last_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      m_clr_n_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      hit_q     <= hit_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      m_clr_n_q <= m_clr_n_d;
    end
  end

  // x_out is taken directly from the shift register MSB so each bit is
  // presented for exactly the one SHIFT cycle it belongs to.
  assign x_out      = (state_q == SHIFT) && shreg_q[WIDTH-1];
  assign m_clr_n    = m_clr_n_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign hit_count  = hit_q;
  assign last_state = last_q;

endmodule
